// File: rtl/mdu_seq.sv
// mdu_seq - sequential RV32M multiply/divide unit.
//
// This unit accepts one operation at a time from the ID side. A multiply uses a
// shift-add datapath and a divide uses a restoring datapath. Each processes one
// operand bit per cycle. A divide by zero and the signed overflow divide take a
// short path and skip the iteration phase. The unit holds each result in DONE
// until the consumer acknowledges it.
//
// Ports
//   clk       rising-edge clock
//   rstn_i    asynchronous active-low reset
//   flush_i   discard any operation in flight (outranks everything)
//   halt_i    freeze all state (flush_i still acts)
//   valid_i   operation request from ID side
//   ack_o     request accepted this cycle (combinational)
//   op_i      RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_i     operand A / dividend
//   rs2_i     operand B / divisor
//   ack_i     consumer took the result
//   valid_o   result_o valid
//   result_o  operation result
//   busy_o    unit not idle (registered state only)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation held, ready to accept
// CALC  | iterating, 32 bit-steps then one result-selection step
// DONE  | result presented on result_o until ack_i

module mdu_seq (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        halt_i,
  input  logic        valid_i,
  output logic        ack_o,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        ack_i,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic        busy_o
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [63:0] acc_q;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opb_q;     // mul: multiplicand magnitude; div: divisor magnitude
  logic        neg_q;
  logic [4:0]  cnt_q;     // down-counter, terminal count at 0
  logic        fin_q;     // all 32 bit-steps done, next CALC cycle selects result
  logic [31:0] result_q;

  logic        accept;

  // operand preparation
  logic        sgn_a, sgn_b;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic        neg_d;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_res;

  // iteration and result selection
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] mul_full;
  logic [31:0] mul_res;
  logic [31:0] div_mag;
  logic [31:0] div_res;
  logic [31:0] final_res;

  // rstn_i gates the accept so nothing is acknowledged while reset is held.
  assign accept = rstn_i & valid_i & ~halt_i & ~flush_i &
                  ((state_q == S_IDLE) | ((state_q == S_DONE) & ack_i));

  always_comb begin
    sgn_a = (op_i == OP_MULH) | (op_i == OP_MULHSU) | (op_i[2] & ~op_i[0]);
    sgn_b = (op_i == OP_MULH) | (op_i[2] & ~op_i[0]);
    neg_a = sgn_a & rs1_i[31];
    neg_b = sgn_b & rs2_i[31];
    mag_a = neg_a ? (~rs1_i + 32'd1) : rs1_i;
    mag_b = neg_b ? (~rs2_i + 32'd1) : rs2_i;
    // A remainder follows the dividend sign. Every other result follows the XOR
    // of the signs. For unsigned operands both neg_a and neg_b are already 0.
    neg_d = (op_i[2] & op_i[1]) ? neg_a : (neg_a ^ neg_b);

    div_zero = (rs2_i == 32'd0);
    div_ovf  = ~op_i[0] & (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);
    special  = op_i[2] & (div_zero | div_ovf);
    if (div_zero) begin
      special_res = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
    end else begin
      special_res = op_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  always_comb begin
    // Shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole register right by one.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Restoring step: shift the next dividend bit into the remainder and try to
    // subtract. Because the remainder stays below the divisor, bit 32 of the
    // difference is a clean borrow flag.
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = div_sh - {1'b0, opb_q};
    if (!div_diff[32]) begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_next = {div_sh[31:0], acc_q[30:0], 1'b0};
    end

    // The sign is applied to the full 64-bit product before the slice is taken.
    mul_full  = neg_q ? (~acc_q + 64'd1) : acc_q;
    mul_res   = (op_q == OP_MUL) ? mul_full[31:0] : mul_full[63:32];
    div_mag   = op_q[1] ? acc_q[63:32] : acc_q[31:0];
    div_res   = neg_q ? (~div_mag + 32'd1) : div_mag;
    final_res = op_q[2] ? div_res : mul_res;
  end

  // state register
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else if (!halt_i) begin
      case (state_q)
        S_IDLE: begin
          if (accept) state_d = special ? S_DONE : S_CALC;
        end
        S_CALC: begin
          if (fin_q) state_d = S_DONE;
        end
        S_DONE: begin
          if (ack_i) begin
            if (accept) state_d = special ? S_DONE : S_CALC;
            else        state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    ack_o    = accept;
    valid_o  = (state_q == S_DONE) & ~flush_i;
    busy_o   = (state_q != S_IDLE);
    result_o = result_q;
  end

  // datapath and iteration counter
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      op_q     <= 3'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      neg_q    <= 1'b0;
      cnt_q    <= 5'd0;
      fin_q    <= 1'b0;
      result_q <= 32'd0;
    end else if (flush_i) begin
      cnt_q <= 5'd0;
      fin_q <= 1'b0;
    end else if (!halt_i) begin
      if (accept) begin
        op_q  <= op_i;
        neg_q <= neg_d;
        fin_q <= 1'b0;
        cnt_q <= special ? 5'd0 : 5'd31;
        if (op_i[2]) begin
          acc_q <= {32'd0, mag_a};
          opb_q <= mag_b;
        end else begin
          acc_q <= {32'd0, mag_b};
          opb_q <= mag_a;
        end
        if (special) result_q <= special_res;
      end else if (state_q == S_CALC) begin
        if (fin_q) begin
          result_q <= final_res;
          fin_q    <= 1'b0;
        end else begin
          acc_q <= op_q[2] ? div_next : mul_next;
          if (cnt_q == 5'd0) fin_q <= 1'b1;
          else               cnt_q <= cnt_q - 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq. It drives inputs on the falling edge and
// samples the DUT outputs on the falling edge. When an operation is issued,
// its expected result goes into a queue. The entry is popped when valid_o
// shows up.

module tb_mdu_seq;

  logic        clk;
  logic        rstn_i;
  logic        flush_i;
  logic        halt_i;
  logic        valid_i;
  logic        ack_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        ack_i;
  logic        valid_o;
  logic [31:0] result_o;
  logic        busy_o;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  mdu_seq dut (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .flush_i  (flush_i),
    .halt_i   (halt_i),
    .valid_i  (valid_i),
    .ack_o    (ack_o),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .ack_i    (ack_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference arithmetic built from plain 64-bit integer operations.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 0;
    return 33;
  endfunction

  // Called at a falling edge. Presents a request, records ack_o, and crosses the
  // accept edge. It returns at the falling edge after the accept edge, where the
  // latency count is 0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic acked);
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    valid_i = 1'b1;
    #1 acked = ack_o;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Counts the active edges after the accept edge until valid_o is seen.
  task automatic wait_valid(input int budget, output int lat, output bit ok);
    lat = 0;
    while (valid_o !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    ok = (valid_o === 1'b1);
  endtask

  task automatic test_reset;
    rstn_i  = 1'b0;
    valid_i = 1'b1;
    ack_i   = 1'b1;
    op_i    = 3'd0;
    rs1_i   = 32'd3;
    rs2_i   = 32'd4;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ack_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b valid=%b busy=%b result=%h, want 0 0 0 0",
               ack_o, valid_o, busy_o, result_o);
    end
    @(negedge clk);
    valid_i = 1'b0;
    rstn_i  = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_basic;
    logic acked; int lat; bit ok; logic [31:0] e;
    ack_i = 1'b1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, acked);
    checks++;
    if (acked !== 1'b1) begin failures++; $display("FAIL mul_ack: got %b want 1", acked); end
    exp_q.push_back(32'hFFFF_FFEB);
    wait_valid(60, lat, ok);
    checks++;
    if (!ok || lat != 33) begin failures++; $display("FAIL mul_latency: got %0d want 33", lat); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL mul_result: scoreboard empty"); end
    else begin
      e = exp_q.pop_front();
      if (result_o !== e) begin failures++; $display("FAIL mul_result: got %h want %h", result_o, e); end
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL mul_drop: valid=%b busy=%b want 0 0", valid_o, busy_o);
    end
  endtask

  task automatic test_mul_high;
    vec_t tbl[$]; logic acked; int lat; bit ok; logic [31:0] e;
    ack_i = 1'b1;
    tbl.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    tbl.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33});
    tbl.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, model(3'd1, 32'h8000_0000, 32'h8000_0000), 33});
    tbl.push_back('{3'd1, 32'hFFFF_FFFD, 32'd5, model(3'd1, 32'hFFFF_FFFD, 32'd5), 33});
    tbl.push_back('{3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, model(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF), 33});
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, acked);
      checks++;
      if (acked !== 1'b1) begin failures++; $display("FAIL mulh_ack[%0d]: got %b want 1", i, acked); end
      exp_q.push_back(tbl[i].exp);
      wait_valid(60, lat, ok);
      checks++;
      if (!ok || lat != tbl[i].lat) begin
        failures++; $display("FAIL mulh_latency[%0d]: got %0d want %0d", i, lat, tbl[i].lat);
      end
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL mulh_result[%0d]: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front();
        if (result_o !== e) begin failures++; $display("FAIL mulh_result[%0d]: got %h want %h", i, result_o, e); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_divide;
    vec_t tbl[$]; logic acked; int lat; bit ok; logic [31:0] e;
    ack_i = 1'b1;
    tbl.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0});
    tbl.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
    tbl.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0});
    tbl.push_back('{3'd7, 32'd1234, 32'd0, 32'd1234, 0});
    tbl.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0});
    tbl.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
    tbl.push_back('{3'd4, 32'hFFFF_FF9C, 32'd7, model(3'd4, 32'hFFFF_FF9C, 32'd7), 33});
    tbl.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 33});
    tbl.push_back('{3'd7, 32'hFFFF_FFFF, 32'd10, 32'd5, 33});
    tbl.push_back('{3'd6, 32'd100, 32'hFFFF_FFF9, model(3'd6, 32'd100, 32'hFFFF_FFF9), 33});
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, acked);
      checks++;
      if (acked !== 1'b1) begin failures++; $display("FAIL div_ack[%0d]: got %b want 1", i, acked); end
      exp_q.push_back(tbl[i].exp);
      wait_valid(60, lat, ok);
      checks++;
      if (!ok || lat != tbl[i].lat) begin
        failures++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, tbl[i].lat);
      end
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL div_result[%0d]: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front();
        if (result_o !== e) begin failures++; $display("FAIL div_result[%0d]: got %h want %h", i, result_o, e); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic acked; int lat; bit ok; logic [31:0] e;
    ack_i = 1'b0;
    issue(3'd5, 32'd100, 32'd7, acked);
    exp_q.push_back(32'd14);
    wait_valid(60, lat, ok);
    checks++;
    if (!ok || lat != 33) begin failures++; $display("FAIL bp_latency: got %0d want 33", lat); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL bp_result: scoreboard empty"); end
    else begin
      e = exp_q.pop_front();
      if (result_o !== e) begin failures++; $display("FAIL bp_result: got %h want %h", result_o, e); end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || result_o !== 32'd14) begin
        failures++; $display("FAIL bp_hold[%0d]: valid=%b result=%h want 1 0000000e", i, valid_o, result_o);
      end
    end
    ack_i = 1'b1;
    issue(3'd0, 32'd12345, 32'd678, acked);
    checks++;
    if (acked !== 1'b1) begin failures++; $display("FAIL b2b_ack: got %b want 1", acked); end
    exp_q.push_back(model(3'd0, 32'd12345, 32'd678));
    checks++;
    if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
      failures++; $display("FAIL b2b_calc: busy=%b valid=%b want 1 0", busy_o, valid_o);
    end
    wait_valid(60, lat, ok);
    checks++;
    if (!ok || lat != 33) begin failures++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_result: scoreboard empty"); end
    else begin
      e = exp_q.pop_front();
      if (result_o !== e) begin failures++; $display("FAIL b2b_result: got %h want %h", result_o, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    logic acked; int lat; bit ok; bit seen;
    ack_i = 1'b1;
    issue(3'd5, 32'd1000, 32'd3, acked);
    exp_q.push_back(model(3'd5, 32'd1000, 32'd3));
    repeat (14) @(negedge clk);
    flush_i = 1'b1;
    valid_i = 1'b1;
    #1;
    checks++;
    if (ack_o !== 1'b0) begin failures++; $display("FAIL flush_ack: got %b want 0", ack_o); end
    @(negedge clk);
    flush_i = 1'b0;
    valid_i = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_idle: busy=%b want 0", busy_o); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (valid_o === 1'b1) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL flush_no_valid: valid_o seen after flush"); end

    ack_i = 1'b0;
    issue(3'd0, 32'd3, 32'd4, acked);
    exp_q.push_back(32'd12);
    wait_valid(60, lat, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL flush_done_wait: no valid after %0d cycles", lat); end
    flush_i = 1'b1;
    ack_i   = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL flush_mask: valid=%b want 0", valid_o); end
    void'(exp_q.pop_front());
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++; $display("FAIL flush_done_idle: busy=%b valid=%b want 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_halt;
    logic acked; int lat; logic [31:0] e;
    ack_i   = 1'b1;
    halt_i  = 1'b1;
    valid_i = 1'b1;
    #1;
    checks++;
    if (ack_o !== 1'b0) begin failures++; $display("FAIL halt_ack: got %b want 0", ack_o); end
    @(negedge clk);
    halt_i  = 1'b0;
    valid_i = 1'b0;
    issue(3'd1, 32'hFFFE_1DC0, 32'd789, acked);
    exp_q.push_back(model(3'd1, 32'hFFFE_1DC0, 32'd789));
    lat = 0;
    while (valid_o !== 1'b1 && lat < 80) begin
      halt_i = (lat >= 10 && lat < 15);
      if (lat == 12) begin
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL halt_busy: got %b want 1", busy_o); end
      end
      @(negedge clk);
      lat++;
    end
    halt_i = 1'b0;
    checks++;
    if (lat != 38) begin failures++; $display("FAIL halt_latency: got %0d want 38", lat); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL halt_result: scoreboard empty"); end
    else begin
      e = exp_q.pop_front();
      if (result_o !== e) begin failures++; $display("FAIL halt_result: got %h want %h", result_o, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic acked; bit seen;
    ack_i = 1'b1;
    issue(3'd4, 32'hFFFF_FFCE, 32'd3, acked);
    exp_q.push_back(model(3'd4, 32'hFFFF_FFCE, 32'd3));
    repeat (10) @(negedge clk);
    valid_i = 1'b1;
    rstn_i  = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'd0 || ack_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: busy=%b valid=%b result=%h ack=%b want 0 0 0 0",
               busy_o, valid_o, result_o, ack_o);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    valid_i = 1'b0;
    rstn_i  = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (valid_o === 1'b1 || busy_o === 1'b1) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL rst_mid_quiet: valid_o or busy_o after reset"); end
  endtask

  task automatic test_back_to_back;
    logic acked; int lat; bit ok; logic [31:0] e;
    logic [2:0] op; logic [31:0] a, b; int k, want_lat;
    ack_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      k  = $urandom_range(0, 5);
      if (k == 0) b = 32'd0;
      if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (k == 2) b = 32'($urandom_range(1, 300));
      want_lat = model_lat(op, a, b);
      issue(op, a, b, acked);
      checks++;
      if (acked !== 1'b1) begin failures++; $display("FAIL rnd_ack[%0d]: got %b want 1", i, acked); end
      exp_q.push_back(model(op, a, b));
      wait_valid(60, lat, ok);
      checks++;
      if (!ok || lat != want_lat) begin
        failures++; $display("FAIL rnd_latency[%0d]: op=%0d got %0d want %0d", i, op, lat, want_lat);
      end
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_result[%0d]: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front();
        if (result_o !== e) begin
          failures++;
          $display("FAIL rnd_result[%0d]: op=%0d a=%h b=%h got %h want %h", i, op, a, b, result_o, e);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn_i   = 1'b0;
    flush_i  = 1'b0;
    halt_i   = 1'b0;
    valid_i  = 1'b0;
    ack_i    = 1'b0;
    op_i     = 3'd0;
    rs1_i    = 32'd0;
    rs2_i    = 32'd0;
    test_reset;
    test_mul_basic;
    test_mul_high;
    test_divide;
    test_backpressure;
    test_flush;
    test_halt;
    test_reset_mid;
    test_back_to_back;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
